// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default operand width.
package serial_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } sa_state_t;

    localparam int SA_W_DEFAULT = 8;

endpackage

// File: rtl/serial_add_if.sv
// Request/result bundle between a requester (master) and serial_add_ctrl (slave).
// ovf is present only when SERIAL_ADD_OVF_EN is defined.
interface serial_add_if #(
    parameter int W = serial_add_pkg::SA_W_DEFAULT
);

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, ovf
    );
`else
    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
`endif

endinterface

// File: rtl/full_add.sv
// One-bit full adder cell used as the serial datapath.
// Purely combinational; no handshake.
module full_add (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);

    assign Sum  = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial W-bit adder: one full_add cell stepped LSB-first, carry held between cycles.
// Latency: start accepted at edge N -> done in cycle N+W+1; start ignored while busy.
// SERIAL_ADD_OVF_EN adds a signed-overflow flag held alongside cout.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int W = SA_W_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    serial_add_if.slave bus
);

    localparam int               CNT_W    = $clog2(W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    sa_state_t        state_q, state_d;
    logic [W-1:0]     a_sh_q, a_sh_d;
    logic [W-1:0]     b_sh_q, b_sh_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             fa_sum, fa_cout;
    logic             last_bit;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    assign last_bit = (count_q == CNT_LAST);

    full_add u_cell (
        .A    (a_sh_q[0]),
        .B    (b_sh_q[0]),
        .Cin  (carry_q),
        .Sum  (fa_sum),
        .Cout (fa_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (bus.start) state_d = ST_SHIFT;
            ST_SHIFT: if (last_bit)  state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        unique case (state_q)
            ST_SHIFT: bus.busy = 1'b1;
            ST_DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
            end
            default: ;
        endcase
    end

    // Result bits enter at the MSB so that after W steps bit 0 sits at sum[0].
    always_comb begin
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        count_d = count_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    carry_d = bus.cin;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    count_d = '0;
`ifdef SERIAL_ADD_OVF_EN
                    ovf_d   = 1'b0;
`endif
                end
            end
            ST_SHIFT: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                sum_d   = {fa_sum, sum_q[W-1:1]};
                carry_d = fa_cout;
                count_d = count_q + 1'b1;
                if (last_bit) begin
                    cout_d  = fa_cout;
                    count_d = '0;
`ifdef SERIAL_ADD_OVF_EN
                    // carry_q is the carry into the MSB on this step
                    ovf_d   = carry_q ^ fa_cout;
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            count_q <= '0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            count_q <= count_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (W=8 and W=3 instances); checks ovf when SERIAL_ADD_OVF_EN is defined.
module tb_serial_add_ctrl;

    logic clk;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;

    serial_add_if #(.W(8)) if8 ();
    serial_add_if #(.W(3)) if3 ();

    serial_add_ctrl #(.W(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));
    serial_add_ctrl #(.W(3)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t tbl [6];

    function automatic int sgn(input int w, input int v);
        return (v >= (1 << (w - 1))) ? v - (1 << w) : v;
    endfunction

    function automatic logic ref_ovf(input int w, input int a, input int b, input int c);
        int s;
        s = sgn(w, a) + sgn(w, b) + c;
        return (s > (1 << (w - 1)) - 1) || (s < -(1 << (w - 1)));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // One W=8 operation; optional stray start (with different operands) at cycle glitch.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic c, input logic [7:0] es, input logic ec,
                          input logic eo, input int glitch);
        int         lat;
        int         busy_n;
        int         done_n;
        logic [7:0] gs;
        logic       gc;
        logic       go;
        lat = 0; busy_n = 0; done_n = 0; gs = '0; gc = 1'b0; go = 1'b0;
        @(negedge clk);
        if8.start = 1'b1; if8.a = a; if8.b = b; if8.cin = c;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            if (if8.busy) busy_n++;
            if (if8.done) begin
                done_n++;
                lat = cyc;
                gs  = if8.sum;
                gc  = if8.cout;
`ifdef SERIAL_ADD_OVF_EN
                go  = if8.ovf;
`endif
            end
            if (cyc == glitch) begin
                if8.start = 1'b1; if8.a = 8'h11; if8.b = 8'h11; if8.cin = 1'b1;
            end else begin
                if8.start = 1'b0;
                if8.a = 8'($urandom); if8.b = 8'($urandom); if8.cin = 1'($urandom);
            end
        end
        check({tag, "_latency"}, lat, 9);
        check({tag, "_busy_cycles"}, busy_n, 9);
        check({tag, "_done_pulses"}, done_n, 1);
        check({tag, "_sum"}, {24'd0, gs}, {24'd0, es});
        check({tag, "_cout"}, {31'd0, gc}, {31'd0, ec});
        check({tag, "_sum_held"}, {23'd0, if8.cout, if8.sum}, {23'd0, ec, es});
`ifdef SERIAL_ADD_OVF_EN
        check({tag, "_ovf"}, {31'd0, go}, {31'd0, eo});
        check({tag, "_ovf_held"}, {31'd0, if8.ovf}, {31'd0, eo});
`else
        if (eo === 1'bx) $display("note: %s ovf reference undefined", tag);
`endif
    endtask

    int         done_n;
    int         total;
    logic [7:0] ra, rb;
    logic       rc;
    int         n3, last_done, cyc3, idx, t3;
    int         q3 [$];

    initial begin
        tbl[0] = '{8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        tbl[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[4] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1};
        tbl[5] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};

        rst = 1'b1;
        if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0;
        if3.start = 1'b0; if3.a = '0; if3.b = '0; if3.cin = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, if8.busy}, 0);
        check("reset_done", {31'd0, if8.done}, 0);
        check("reset_sum", {24'd0, if8.sum}, 0);
        check("reset_cout", {31'd0, if8.cout}, 0);
        check("reset_busy_w3", {31'd0, if3.busy}, 0);
`ifdef SERIAL_ADD_OVF_EN
        check("reset_ovf", {31'd0, if8.ovf}, 0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 6; i++)
            run_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin,
                   tbl[i].sum, tbl[i].cout, tbl[i].ovf, 0);

        // Stray start during SHIFT, then during DONE: both must be ignored.
        run_op("ign_shift", 8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0, 3);
        run_op("ign_done", 8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0, 9);

        // Reset at the 4th SHIFT cycle aborts without a done pulse.
        @(negedge clk);
        if8.start = 1'b1; if8.a = 8'h3C; if8.b = 8'h05; if8.cin = 1'b0;
        @(negedge clk);
        if8.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {31'd0, if8.busy}, 0);
        check("abort_done", {31'd0, if8.done}, 0);
        check("abort_sum", {24'd0, if8.sum}, 0);
        check("abort_cout", {31'd0, if8.cout}, 0);
        done_n = 0;
        repeat (12) begin
            @(negedge clk);
            if (if8.done) done_n++;
        end
        check("abort_no_done", done_n, 0);
        run_op("after_abort", 8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0, 0);

        // Reset wins over start in the same cycle.
        @(negedge clk);
        rst = 1'b1; if8.start = 1'b1; if8.a = 8'hFF; if8.b = 8'hFF;
        @(negedge clk);
        check("rst_prio_busy", {31'd0, if8.busy}, 0);
        rst = 1'b0; if8.start = 1'b0;
        @(negedge clk);
        check("rst_prio_idle", {31'd0, if8.busy}, 0);

        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            total = int'(ra) + int'(rb) + int'(rc);
            run_op($sformatf("rnd%0d", i), ra, rb, rc, 8'(total), 1'(total >> 8),
                   ref_ovf(8, int'(ra), int'(rb), int'(rc)), 0);
        end

        // W=3 exhaustive sweep with start held high.
        n3 = 0; last_done = -1; cyc3 = 0; idx = 1;
        @(negedge clk);
        if3.start = 1'b1; if3.a = 3'd0; if3.b = 3'd0; if3.cin = 1'b0;
        q3.push_back(0);
        while (n3 < 128 && cyc3 < 128 * 5 + 40) begin
            @(negedge clk);
            cyc3++;
            if (if3.done) begin
                if (q3.size() == 0) begin
                    check("w3_extra_done", 1, 0);
                end else begin
                    t3 = q3.pop_front();
                    total = (t3 >> 4) + ((t3 >> 1) & 7) + (t3 & 1);
                    check($sformatf("w3_res%0d", t3), {28'd0, if3.cout, if3.sum}, 32'(total));
`ifdef SERIAL_ADD_OVF_EN
                    check($sformatf("w3_ovf%0d", t3), {31'd0, if3.ovf},
                          {31'd0, ref_ovf(3, t3 >> 4, (t3 >> 1) & 7, t3 & 1)});
`endif
                end
                if (last_done >= 0) check($sformatf("w3_gap%0d", n3), cyc3 - last_done, 5);
                last_done = cyc3;
                n3++;
                if (idx < 128) begin
                    if3.a = 3'(idx >> 4); if3.b = 3'(idx >> 1); if3.cin = 1'(idx);
                    q3.push_back(idx);
                    idx++;
                end else begin
                    if3.start = 1'b0;
                end
            end
        end
        check("w3_result_count", n3, 128);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
